alu_result_fifo: RTL and testbench

//  Downstream capture stage for the 8-bit ALU. Each cycle the producer asserts in_valid,
//  and the block stores the ALU's {sel, result, carry, zero} tuple in a DEPTH-entry FIFO.

---
 rtl/alu_result_fifo.sv | 112 +++++++++++
 tb/tb_alu_result_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT capture FIFO for ALU result tuples
// with saturating carry/zero stats and a sticky illegal-opcode flag.
module alu_result_fifo #(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int MAX_SEL = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_sel,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic [CNT_W-1:0]         zero_cnt,
  output logic                     illegal_sel,
  input  logic                     clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int ENT_W = SEL_W + DATA_W + 2;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [SEL_W-1:0]  head_sel;
  logic [DATA_W-1:0] head_result;
  logic              head_carry;
  logic              head_zero;
  logic              bad_sel;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign bad_sel   = (in_sel > SEL_W'(MAX_SEL));

  assign {head_sel, head_result, head_carry, head_zero} = mem[rd_ptr];

  // Head entry falls through; outputs forced to zero when empty.
  always_comb begin
    out_sel    = '0;
    out_result = '0;
    out_carry  = 1'b0;
    out_zero   = 1'b0;
    if (out_valid) begin
      out_sel    = head_sel;
      out_result = head_result;
      out_carry  = head_carry;
      out_zero   = head_zero;
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_sel, in_result, in_carry, in_zero};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Statistics; a clear drops the same-cycle push contribution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt   <= '0;
      zero_cnt    <= '0;
      illegal_sel <= 1'b0;
    end else if (clr_stats) begin
      carry_cnt   <= '0;
      zero_cnt    <= '0;
      illegal_sel <= 1'b0;
    end else if (push) begin
      if (in_carry && carry_cnt != '1)
        carry_cnt <= carry_cnt + 1'b1;
      if (in_zero && zero_cnt != '1)
        zero_cnt <= zero_cnt + 1'b1;
      if (bad_sel)
        illegal_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed scoreboard bench
// for the ALU result capture FIFO.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] res;
    logic       c;
    logic       z;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sel;
  logic [7:0] in_result;
  logic       in_carry;
  logic       in_zero;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sel;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic [2:0] count;
  logic [7:0] carry_cnt;
  logic [7:0] zero_cnt;
  logic       illegal_sel;
  logic       clr_stats;

  item_t q[$];
  int    m_carry;
  int    m_zero;
  bit    m_ill;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  alu_result_fifo dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_result(in_result),
    .in_carry(in_carry), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero),
    .count(count), .carry_cnt(carry_cnt),
    .zero_cnt(zero_cnt), .illegal_sel(illegal_sel),
    .clr_stats(clr_stats)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s,
                       input logic [7:0] r, input logic c,
                       input logic z);
    in_valid  = v;
    in_sel    = s;
    in_result = r;
    in_carry  = c;
    in_zero   = z;
  endtask

  // Check state, update the model for this cycle, advance one edge.
  task automatic cyc();
    item_t h;
    item_t n;
    bit    mpush;
    bit    mpop;
    int    sz;
    sz = q.size();
    chk("count", 32'(count), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("carry_cnt", 32'(carry_cnt), 32'(m_carry));
    chk("zero_cnt", 32'(zero_cnt), 32'(m_zero));
    chk("illegal_sel", 32'(illegal_sel), 32'(m_ill));
    if (sz == 0) begin
      chk("empty_outs",
          32'({out_sel, out_result, out_carry, out_zero}), 0);
    end else begin
      h = q[0];
      chk("out_sel", 32'(out_sel), 32'(h.sel));
      chk("out_result", 32'(out_result), 32'(h.res));
      chk("out_carry", 32'(out_carry), 32'(h.c));
      chk("out_zero", 32'(out_zero), 32'(h.z));
    end
    mpush = in_valid && (sz != DEPTH);
    mpop  = out_ready && (sz != 0);
    if (mpop)
      void'(q.pop_front());
    if (mpush) begin
      n = '{in_sel, in_result, in_carry, in_zero};
      q.push_back(n);
    end
    if (clr_stats) begin
      m_carry = 0;
      m_zero  = 0;
      m_ill   = 1'b0;
    end else if (mpush) begin
      if (in_carry && m_carry < 255) m_carry++;
      if (in_zero && m_zero < 255) m_zero++;
      if (in_sel > 4'd11) m_ill = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++)
      if (q.size() != 0) cyc();
    chk("drained", 32'(q.size()), 0);
  endtask

  initial begin
    logic [7:0] alu [4];
    alu[0] = 8'd13;
    alu[1] = 8'd7;
    alu[2] = 8'd2;
    alu[3] = 8'd11;
    m_carry   = 0;
    m_zero    = 0;
    m_ill     = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_stats",
        32'({carry_cnt, zero_cnt, illegal_sel}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();

    // Fill with opcodes 0..3, then a dropped 5th push.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), alu[i], 1'b0, (i == 2));
      cyc();
    end
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1'b1, 4'd9, 8'hee, 1'b1, 1'b1);
    cyc();
    chk("no_overwrite_cnt", 32'(count), 4);
    drain();

    // Steady push and pop at count=2.
    out_ready = 1'b0;
    drive(1'b1, 4'd4, 8'h40, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 4'd5, 8'h51, 1'b1, 1'b0);
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), 8'(8'h60 + i), i[0], i[1]);
      cyc();
      chk("steady_count", 32'(count), 2);
    end
    drain();

    // Saturation of carry and zero counters.
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 4'(i % 12), 8'($urandom), 1'b1, 1'b1);
      cyc();
    end
    chk("carry_sat", 32'(carry_cnt), 255);
    chk("zero_sat", 32'(zero_cnt), 255);
    drain();

    // Sticky illegal opcode, then clear racing a push.
    drive(1'b1, 4'd12, 8'h5a, 1'b0, 1'b0);
    cyc();
    chk("illegal_set", 32'(illegal_sel), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i + 6), 8'(i), 1'b0, 1'b0);
      cyc();
    end
    chk("illegal_sticky", 32'(illegal_sel), 1);
    clr_stats = 1'b1;
    drive(1'b1, 4'd1, 8'h99, 1'b1, 1'b0);
    cyc();
    clr_stats = 1'b0;
    chk("clr_carry", 32'(carry_cnt), 0);
    chk("clr_illegal", 32'(illegal_sel), 0);
    drain();

    // Reset mid-operation discards entries at once.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 1), 8'(8'h30 + i), 1'b0, 1'b0);
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(count), 0);
    q.delete();
    m_carry = 0;
    m_zero  = 0;
    m_ill   = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 4'd5, 8'h77, 1'b0, 1'b0);
    chk("fwft_pre_valid", 32'(out_valid), 0);
    cyc();
    in_valid = 1'b0;
    chk("fwft_valid", 32'(out_valid), 1);
    chk("fwft_sel", 32'(out_sel), 5);
    cyc();
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
